// File: rtl/adam_aes_inv_subshift.sv
// InvShiftRows + InvSubBytes stage: one 32-bit word per cycle through a shared external inverse S-box.
// Define ADAM_AES_INV_SHIFT_EN to apply InvShiftRows at capture; otherwise the block is captured unchanged.
module adam_aes_inv_subshift (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic [1:0]   dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t         fsm_q;
    logic [1:0]   word_ctr_q;
    logic [127:0] state_q;
    logic [127:0] state_d;
    logic [127:0] capture_w;

    // Byte s[r][c] lives at bits 127-8*(4c+r); destination column c takes source column (c-r) mod 4.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] t;
        t = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r) & 3) + r) -: 8];
            end
        end
        return t;
    endfunction

`ifdef ADAM_AES_INV_SHIFT_EN
    assign capture_w = inv_shift_rows(in_block);
`else
    assign capture_w = in_block;
`endif

    // Handshake: a block moves on a rising edge where valid and ready are both high; ready/valid
    // depend on FSM state only, and out_block is held stable while out_valid waits for out_ready.
    assign in_ready    = (fsm_q == IDLE);
    assign out_valid   = (fsm_q == DONE);
    assign out_block   = state_q;
    assign dbg_state_o = fsm_q;

    always_comb begin
        sboxw = state_q[127:96];
        if (fsm_q == SUB) begin
            case (word_ctr_q)
                2'd0:    sboxw = state_q[127:96];
                2'd1:    sboxw = state_q[95:64];
                2'd2:    sboxw = state_q[63:32];
                default: sboxw = state_q[31:0];
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        if (!clear) begin
            if (fsm_q == IDLE && in_valid) begin
                state_d = capture_w;
            end else if (fsm_q == SUB) begin
                case (word_ctr_q)
                    2'd0:    state_d[127:96] = new_sboxw;
                    2'd1:    state_d[95:64]  = new_sboxw;
                    2'd2:    state_d[63:32]  = new_sboxw;
                    default: state_d[31:0]   = new_sboxw;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q      <= IDLE;
            word_ctr_q <= 2'd0;
            state_q    <= '0;
        end else begin
            state_q <= state_d;
            if (clear) begin
                fsm_q      <= IDLE;
                word_ctr_q <= 2'd0;
            end else begin
                case (fsm_q)
                    IDLE: begin
                        if (in_valid) begin
                            fsm_q      <= SUB;
                            word_ctr_q <= 2'd0;
                        end
                    end
                    SUB: begin
                        word_ctr_q <= word_ctr_q + 2'd1;
                        if (word_ctr_q == 2'd3) begin
                            fsm_q <= DONE;
                        end
                    end
                    DONE: begin
                        if (out_ready) begin
                            fsm_q <= IDLE;
                        end
                    end
                    default: fsm_q <= IDLE;
                endcase
            end
        end
    end

endmodule
